// File: rtl/oled_init_seq_pkg.sv
// Shared definitions for the OLED power-up sequencer.
//   TX_CMD / TX_DATA : control bytes presented on tx_dc
//   INIT_LEN/INIT_ROM: fixed SSD1306 power-up command list
//   state_t          : sequencer state encoding
package oled_pkg;

    localparam logic [7:0] TX_CMD  = 8'h00;
    localparam logic [7:0] TX_DATA = 8'h40;

    localparam int INIT_LEN = 24;

    localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
        8'h8D, 8'h14, 8'h20, 8'h02, 8'hA1, 8'hC8, 8'hDA, 8'h12,
        8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6
    };

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_PG_SET,
        S_COL_LO,
        S_COL_HI,
        S_FILLB,
        S_DISP_ON,
        S_DONE
    } state_t;

endpackage

// File: rtl/oled_init_seq_tx_hs.sv
// Request/acknowledge handshake toward the I2C single-transfer stage.
//   clk, rst            : clock, synchronous active-high reset
//   load, load_dc/data  : latch a new byte pair and start the re-arm gap
//   tx_ack              : downstream completion (level or pulse)
//   tx_req, tx_dc/data  : request and the byte pair it carries
//   xfer_done           : one-cycle strobe on the edge an ack is accepted
module oled_tx_hs #(
    parameter int GAP_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_dc,
    input  logic [7:0] load_data,
    input  logic       tx_ack,
    output logic       tx_req,
    output logic [7:0] tx_dc,
    output logic [7:0] tx_data,
    output logic       xfer_done
);

    localparam int GW = $clog2(GAP_CYC + 1);

    logic          req_seen;   // tx_req has been high for at least one prior cycle
    logic          gap_run;
    logic [GW-1:0] gap_cnt;

    // An ack on the first request cycle, or during the gap, is never accepted.
    assign xfer_done = tx_req & req_seen & tx_ack;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_req   <= 1'b0;
            req_seen <= 1'b0;
            gap_run  <= 1'b0;
            gap_cnt  <= '0;
            tx_dc    <= 8'h00;
            tx_data  <= 8'h00;
        end else if (load) begin
            // Bytes only change here, and load only happens while tx_req is
            // low or on the edge that drops it.
            tx_dc    <= load_dc;
            tx_data  <= load_data;
            tx_req   <= 1'b0;
            req_seen <= 1'b0;
            gap_run  <= 1'b1;
            gap_cnt  <= GW'(GAP_CYC);
        end else if (xfer_done) begin
            tx_req   <= 1'b0;
            req_seen <= 1'b0;
        end else if (gap_run) begin
            if (gap_cnt == GW'(1)) begin
                gap_run <= 1'b0;
                tx_req  <= 1'b1;
            end else begin
                gap_cnt <= gap_cnt - GW'(1);
            end
        end else if (tx_req) begin
            req_seen <= 1'b1;
        end
    end

endmodule

// File: rtl/oled_init_seq.sv
// OLED command/data sequencer: power-up list, full GDDRAM clear, display on.
//   clk, rst        : clock, synchronous active-high reset
//   start           : begins a sequence from IDLE or DONE
//   busy, done      : sequence in progress / sequence complete
//   tx_req/dc/data  : byte pair offered to the I2C stage
//   tx_ack          : downstream completion
module oled_init_seq
    import oled_pkg::*;
#(
    parameter int         PAGES   = 8,
    parameter int         COLS    = 128,
    parameter logic [7:0] FILL    = 8'h00,
    parameter int         GAP_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       tx_req,
    output logic [7:0] tx_dc,
    output logic [7:0] tx_data,
    input  logic       tx_ack
);

    localparam int IW = $clog2(INIT_LEN);
    localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    state_t        state, nxt_state;
    logic [IW-1:0] idx, nxt_idx;
    logic [PW-1:0] page, nxt_page;
    logic [CW-1:0] col, nxt_col;
    logic          armed;      // current state's bytes already handed to the handshake
    logic          load;
    logic [7:0]    ld_dc, ld_data;
    logic          xfer_done;
    logic          in_send;

    assign in_send = (state != S_IDLE) && (state != S_DONE);
    assign busy    = in_send;
    assign done    = (state == S_DONE);

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_page  = page;
        nxt_col   = col;
        case (state)
            S_IDLE, S_DONE: if (start) begin
                nxt_state = S_INIT;
                nxt_idx   = '0;
            end
            S_INIT: if (xfer_done) begin
                if (idx == IW'(INIT_LEN - 1)) begin
                    nxt_state = S_PG_SET;
                    nxt_page  = '0;
                end else begin
                    nxt_idx = idx + 1'b1;
                end
            end
            S_PG_SET: if (xfer_done) nxt_state = S_COL_LO;
            S_COL_LO: if (xfer_done) nxt_state = S_COL_HI;
            S_COL_HI: if (xfer_done) begin
                nxt_state = S_FILLB;
                nxt_col   = '0;
            end
            S_FILLB: if (xfer_done) begin
                if (col == CW'(COLS - 1)) begin
                    if (page == PW'(PAGES - 1)) begin
                        nxt_state = S_DISP_ON;
                    end else begin
                        nxt_state = S_PG_SET;
                        nxt_page  = page + 1'b1;
                    end
                end else begin
                    nxt_col = col + 1'b1;
                end
            end
            S_DISP_ON: if (xfer_done) nxt_state = S_DONE;
            default: nxt_state = S_IDLE;
        endcase
    end

    // Bytes come from the next-state view so the following transfer can be
    // loaded on the very edge the current one is acknowledged; that keeps
    // the low gap between transfers at exactly GAP_CYC cycles.
    always_comb begin
        ld_dc   = TX_CMD;
        ld_data = 8'h00;
        case (nxt_state)
            S_INIT:    ld_data = INIT_ROM[nxt_idx];
            S_PG_SET:  ld_data = 8'hB0 | 8'(nxt_page);
            S_COL_HI:  ld_data = 8'h10;
            S_FILLB: begin
                ld_dc   = TX_DATA;
                ld_data = FILL;
            end
            S_DISP_ON: ld_data = 8'hAF;
            default:   ld_data = 8'h00;
        endcase
    end

    // First send after start loads one cycle after entering INIT; later
    // sends load on the accepting edge of the previous transfer.
    assign load = (xfer_done && nxt_state != S_DONE) || (in_send && !armed);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            page  <= '0;
            col   <= '0;
            armed <= 1'b0;
        end else begin
            state <= nxt_state;
            idx   <= nxt_idx;
            page  <= nxt_page;
            col   <= nxt_col;
            if (load)           armed <= 1'b1;
            else if (xfer_done) armed <= 1'b0;
        end
    end

    oled_tx_hs #(.GAP_CYC(GAP_CYC)) u_hs (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_dc   (ld_dc),
        .load_data (ld_data),
        .tx_ack    (tx_ack),
        .tx_req    (tx_req),
        .tx_dc     (tx_dc),
        .tx_data   (tx_data),
        .xfer_done (xfer_done)
    );

endmodule

// File: tb/tb_oled_init_seq.sv
// Self-checking bench for oled_init_seq: default geometry instance plus a
// reduced PAGES=2/COLS=4/FILL=FF instance, selected by sel.
module tb_oled_init_seq;

    localparam int GAP = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic ack = 1'b0;
    logic sel = 1'b0;

    logic       busy_a, done_a, req_a, busy_b, done_b, req_b;
    logic [7:0] dc_a, data_a, dc_b, data_b;
    logic       m_busy, m_done, m_req;
    logic [7:0] m_dc, m_data;

    oled_init_seq dut_a (
        .clk(clk), .rst(rst), .start(start & ~sel), .busy(busy_a), .done(done_a),
        .tx_req(req_a), .tx_dc(dc_a), .tx_data(data_a), .tx_ack(ack & ~sel)
    );

    oled_init_seq #(.PAGES(2), .COLS(4), .FILL(8'hFF)) dut_b (
        .clk(clk), .rst(rst), .start(start & sel), .busy(busy_b), .done(done_b),
        .tx_req(req_b), .tx_dc(dc_b), .tx_data(data_b), .tx_ack(ack & sel)
    );

    assign m_busy = sel ? busy_b : busy_a;
    assign m_done = sel ? done_b : done_a;
    assign m_req  = sel ? req_b  : req_a;
    assign m_dc   = sel ? dc_b   : dc_a;
    assign m_data = sel ? data_b : data_a;

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] rom [24] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
        8'h8D, 8'h14, 8'h20, 8'h02, 8'hA1, 8'hC8, 8'hDA, 8'h12,
        8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6
    };

    logic [15:0] sbq [$];
    int          xfer_cnt = 0;
    int          low_cnt  = 0;
    bit          gap_armed = 1'b0;
    logic        prev_req = 1'b0;
    logic [15:0] cur = 16'h0;
    int          ack_mode = 0;   // 0 none, 1 pulse 5 cycles after rise, 2 held high
    int          hi_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected transfer list for one complete sequence.
    task automatic push_run(input int pages, input int cols, input logic [7:0] fill);
        for (int i = 0; i < 24; i++) sbq.push_back({8'h00, rom[i]});
        for (int p = 0; p < pages; p++) begin
            sbq.push_back({8'h00, 8'hB0 | 8'(p)});
            sbq.push_back(16'h0000);
            sbq.push_back(16'h0010);
            for (int c = 0; c < cols; c++) sbq.push_back({8'h40, fill});
        end
        sbq.push_back(16'h00AF);
    endtask

    task automatic prep_run(input logic b, input int pages, input int cols, input logic [7:0] fill);
        sel = b;
        sbq.delete();
        push_run(pages, cols, fill);
        xfer_cnt  = 0;
        gap_armed = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (m_done) break;
        end
        check("done_reached", m_done, 1);
    endtask

    task automatic end_run(input int exp_cnt);
        check("xfer_count", xfer_cnt, exp_cnt);
        check("queue_empty", sbq.size(), 0);
        check("end_busy", m_busy, 0);
        check("end_done", m_done, 1);
    endtask

    // Downstream ack model.
    initial forever begin
        @(negedge clk);
        if (m_req) hi_cnt++; else hi_cnt = 0;
        case (ack_mode)
            1:       ack = (hi_cnt == 5);
            2:       ack = 1'b1;
            default: ack = 1'b0;
        endcase
    end

    // Monitor: pops the scoreboard on each request rise, checks byte
    // stability while requested and the low gap between transfers.
    initial forever begin
        @(negedge clk);
        if (m_req && !prev_req) begin
            xfer_cnt++;
            cur = {m_dc, m_data};
            if (sbq.size() == 0) check("unexpected_xfer", cur, 16'hxxxx);
            else check($sformatf("xfer%0d", xfer_cnt), cur, sbq.pop_front());
            if (gap_armed) check("gap_len", low_cnt, GAP);
        end else if (m_req && prev_req) begin
            check("bytes_stable", {m_dc, m_data}, cur);
        end
        if (!m_req) begin
            low_cnt = prev_req ? 1 : low_cnt + 1;
            if (prev_req) gap_armed = 1'b1;
        end
        prev_req = m_req;
    end

    initial begin
        // Reset held 3 cycles with a start pulse inside it.
        rst = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_req", req_a, 0);
        check("rst_dc", dc_a, 0);
        check("rst_data", data_a, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_busy", busy_a, 0);
        check("idle_req", req_a, 0);

        // Full run, pulsed ack, with first-request latency check.
        ack_mode = 1;
        prep_run(1'b0, 8, 128, 8'h00);
        pulse_start();
        check("start_busy", m_busy, 1);
        check("lat_lo", m_req, 0);
        for (int k = 1; k <= GAP; k++) begin
            @(negedge clk);
            check("lat_lo", m_req, 0);
        end
        @(negedge clk);
        check("lat_hi", m_req, 1);
        wait_done(12000);
        end_run(1073);

        // Ack held high; started from DONE.
        ack_mode = 2;
        prep_run(1'b0, 8, 128, 8'h00);
        pulse_start();
        check("redo_done_clr", m_done, 0);
        wait_done(12000);
        end_run(1073);

        // start re-pulsed mid-sequence is ignored.
        prep_run(1'b0, 8, 128, 8'h00);
        pulse_start();
        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            if (xfer_cnt >= 100) break;
        end
        check("reach_100", xfer_cnt, 100);
        pulse_start();
        check("mid_busy", m_busy, 1);
        check("mid_done", m_done, 0);
        wait_done(12000);
        end_run(1073);

        // Reset during page 3 fill while requesting.
        prep_run(1'b0, 8, 128, 8'h00);
        pulse_start();
        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            if (xfer_cnt >= 430 && m_req) break;
        end
        check("reach_pg3_req", m_req, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_req", m_req, 0);
        check("mid_rst_busy", m_busy, 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("late_ack_req", m_req, 0);
            check("late_ack_busy", m_busy, 0);
        end
        prep_run(1'b0, 8, 128, 8'h00);
        pulse_start();
        wait_done(12000);
        end_run(1073);

        // Reduced geometry instance, pulsed ack.
        ack_mode = 1;
        prep_run(1'b1, 2, 4, 8'hFF);
        pulse_start();
        wait_done(2000);
        end_run(39);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/oled_init_seq.md
Name: oled_init_seq

Overview:
- Upstream command/data sequencer for the SSD1306-class OLED path.
- Walks a fixed power-up command list, clears the whole GDDRAM page by page, then turns the display on.
- Presents one (control byte, payload byte) pair at a time to the downstream I2C single-transfer stage over a request/acknowledge handshake.
- Replaces the hand-written step case in the top level.

Parameters:
- PAGES, 8, number of 8-row display pages to clear.
- COLS, 128, columns per page; data bytes written per page.
- FILL, 8'h00, pixel byte written during the clear phase.
- GAP_CYC, 2, cycles tx_req is held low between transfers so the downstream stage re-arms.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins the sequence when idle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  high in DONE; cleared by rst or the next accepted start.
- tx_req  out  1  transfer request to the downstream I2C stage.
- tx_dc  out  8  control byte: 8'h00 command, 8'h40 data.
- tx_data  out  8  payload byte.
- tx_ack  in  1  downstream completion; level or pulse.

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high. Reset dominates every other input on the same edge.
- Reset values: busy=0, done=0, tx_req=0, tx_dc=8'h00, tx_data=8'h00, state=IDLE, all counters 0.
- Handshake:
  - tx_dc and tx_data are stable whenever tx_req=1 and change only while tx_req=0.
  - tx_ack is sampled only when tx_req=1 and tx_req has been high for at least 1 prior cycle; an ack on the first request cycle is ignored.
  - On an accepted ack, tx_req drops on the next edge and stays low exactly GAP_CYC cycles. tx_ack is ignored throughout the gap.
  - A held-high ack therefore completes exactly one transfer per request.
- State machine:
  - IDLE: start=1 -> INIT, idx=0, busy=1, done=0. start while busy is ignored.
  - INIT: send INIT_ROM[idx] with tx_dc=8'h00. After ack, idx++. After entry INIT_LEN-1 -> PG_SET, page=0.
  - PG_SET: send 8'hB0|page (cmd) -> COL_LO.
  - COL_LO: send 8'h00 (cmd) -> COL_HI.
  - COL_HI: send 8'h10 (cmd) -> FILLB, col=0.
  - FILLB: send FILL with tx_dc=8'h40; col++ after each ack.
    - If col==COLS-1 and page==PAGES-1 -> DISP_ON.
    - If col==COLS-1 otherwise -> PG_SET with page++.
  - DISP_ON: send 8'hAF (cmd) -> DONE.
  - DONE: busy=0, done=1; start -> INIT as from IDLE.
- Every send is the same sub-sequence: load bytes, then GAP_CYC low cycles, then request high until an accepted ack.
- Counters:
  - idx is 5 bits, page is 3 bits, col is 7 bits, sized from the parameters with clog2.
  - No wrap-around is permitted; terminal compares use ==.
- Transaction count with defaults: 24 + PAGES*(3+COLS) + 1 = 1073.
- Latency: first tx_req rises GAP_CYC+1 cycles after the start edge.
- rst mid-transfer: tx_req drops on that edge; a later ack is ignored in IDLE.

Decomposition:
- Shared package oled_pkg holds:
  - TX_CMD=8'h00 and TX_DATA=8'h40.
  - INIT_LEN=24 and the INIT_ROM constant array: AE D5 80 A8 3F D3 00 40 8D 14 20 02 A1 C8 DA 12 81 CF D9 F1 DB 40 A4 A6.
  - The state enum.
- One natural sub-module: oled_tx_hs. It owns tx_req, the gap counter and ack qualification; the FSM issues load/fire and receives a one-cycle xfer_done.

Test Plan:
- Reset: hold rst 3 cycles -> all outputs 0; start pulsed with rst=1 -> stays IDLE.
- Full run, ack model responds with a 1-cycle pulse 5 cycles after tx_req rises:
  - exactly 1073 transfers;
  - first is (00,AE), 25th is (00,B0), 28th is (40,00), last is (00,AF);
  - then busy=0 and done=1.
- Ack held constantly high: same 1073-transfer list; no transfer skipped or double-counted; tx_req low exactly GAP_CYC cycles between transfers.
- start re-pulsed at transfer 100: no effect, and the sequence is identical. start in DONE: a second full run begins with (00,AE).
- rst asserted during page 3 fill with tx_req=1: tx_req=0 and busy=0 next cycle; a late ack is ignored; a new start restarts at (00,AE).
- PAGES=2, COLS=4, FILL=8'hFF: exactly 24+14+1=39 transfers; data bytes are (40,FF); page commands are B0 and B1 only.
